// File: rtl/riscv_defines.sv
// riscv_defines: shared LSU access-size encoding and response metadata
package riscv_defines;

    typedef enum logic [1:0] {
        LSU_B = 2'b00,
        LSU_H = 2'b01,
        LSU_W = 2'b10,
        LSU_D = 2'b11
    } lsu_size_e;

    // offset is sized for the widest (64-bit) bus; the top bit stays 0 on a 32-bit bus
    typedef struct packed {
        logic      we;
        lsu_size_e size;
        logic      sgn;
        logic [2:0] offset;
    } lsu_resp_meta_t;

    function automatic logic [7:0] size_mask(input lsu_size_e s);
        return s == LSU_B ? 8'h01 : s == LSU_H ? 8'h03 : s == LSU_W ? 8'h0F : 8'hFF;
    endfunction

endpackage

// File: rtl/lsu_resp_fifo.sv
// lsu_resp_fifo: in-order FIFO of response metadata for accepted bus accesses
module lsu_resp_fifo
    import riscv_defines::*;
#(
    parameter int DEPTH = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           push_i,
    input  logic           pop_i,
    input  lsu_resp_meta_t data_i,
    output lsu_resp_meta_t data_o,
    output logic           full_o,
    output logic           empty_o
);

    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    lsu_resp_meta_t mem_q [DEPTH];
    logic [PW-1:0]  wptr_q, rptr_q;
    logic [CW-1:0]  cnt_q;
    logic           do_push, do_pop;

    // a push into a full FIFO is allowed only when the head leaves in the same cycle
    assign do_push = push_i & (~full_o | pop_i);
    assign do_pop  = pop_i & ~empty_o;
    assign full_o  = cnt_q == CW'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign data_o  = mem_q[rptr_q];

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    // pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= do_push ? nxt(wptr_q) : wptr_q;
            rptr_q <= do_pop ? nxt(rptr_q) : rptr_q;
            cnt_q  <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // storage array, written at the tail
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= data_i;
    end

endmodule

// File: rtl/lsu_obi.sv
// lsu_obi: load/store unit bridging a valid/ready core port to an OBI data port
module lsu_obi
    import riscv_defines::*;
#(
    parameter int DATA_W          = 32,
    parameter int ADDR_W          = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lsu_valid_i,
    output logic              lsu_ready_o,
    input  logic              lsu_we_i,
    input  logic [1:0]        lsu_size_i,
    input  logic              lsu_signed_i,
    input  logic [ADDR_W-1:0] lsu_addr_i,
    input  logic [DATA_W-1:0] lsu_wdata_i,
    output logic              lsu_rvalid_o,
    output logic [DATA_W-1:0] lsu_rdata_o,
    output logic              lsu_err_o,
    output logic              busy_o,
    output logic              data_req_o,
    input  logic              data_gnt_i,
    output logic [ADDR_W-1:0] data_addr_o,
    output logic              data_we_o,
    output logic [DATA_W/8-1:0] data_be_o,
    output logic [DATA_W-1:0] data_wdata_o,
    input  logic [DATA_W-1:0] data_rdata_i,
    input  logic              data_rvalid_i
);

    localparam int BW = DATA_W / 8;
    localparam int OW = $clog2(BW);
    localparam int LW = $clog2(DATA_W);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    logic [CW-1:0]     cnt_q;
    logic              req_q, we_q, rvalid_q, err_q;
    logic [ADDR_W-1:0] addr_q;
    logic [BW-1:0]     be_q;
    logic [DATA_W-1:0] wdata_q, rdata_q;

    lsu_size_e         size;
    logic [OW-1:0]     off;
    logic              bad, acc, acc_ok, acc_bad, resp;
    logic              fifo_full, fifo_empty;
    lsu_resp_meta_t    head;
    logic [DATA_W-1:0] sh, m, ld;
    logic [LW-1:0]     msb;

    assign size = lsu_size_e'(lsu_size_i);
    assign off  = lsu_addr_i[OW-1:0];
    assign bad  = (size == LSU_D & DATA_W == 32)
                | (size == LSU_H & lsu_addr_i[0])
                | (size == LSU_W & |lsu_addr_i[1:0])
                | (size == LSU_D & |lsu_addr_i[2:0]);

    // an erroneous access waits until the bus drains so its response stays in order
    assign lsu_ready_o = ~rst & ~fifo_full & (~req_q | data_gnt_i)
                       & ~(lsu_valid_i & bad & cnt_q != '0);
    assign acc     = lsu_valid_i & lsu_ready_o;
    assign acc_ok  = acc & ~bad;
    assign acc_bad = acc & bad;
    assign resp    = data_rvalid_i & ~fifo_empty;

    lsu_resp_fifo #(.DEPTH(MAX_OUTSTANDING)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (acc_ok),
        .pop_i   (data_rvalid_i),
        .data_i  ({lsu_we_i, size, lsu_signed_i, 3'(off)}),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // lane extraction and sign/zero extension of the returning load
    assign sh  = data_rdata_i >> {head.offset, 3'b000};
    assign m   = ~({DATA_W{1'b1}} << (8 << head.size));
    assign msb = LW'((8 << head.size) - 1);
    assign ld  = (sh & m) | ({DATA_W{head.sgn & sh[msb]}} & ~m);

    assign lsu_rvalid_o = rvalid_q;
    assign lsu_err_o    = err_q;
    assign lsu_rdata_o  = rdata_q;
    assign busy_o       = cnt_q != '0 | rvalid_q;
    assign data_req_o   = req_q;
    assign data_addr_o  = addr_q;
    assign data_we_o    = we_q;
    assign data_be_o    = be_q;
    assign data_wdata_o = wdata_q;

    // request phase, outstanding count and registered core response
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            be_q     <= '0;
            wdata_q  <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            cnt_q    <= cnt_q + CW'(acc_ok) - CW'(resp);
            rvalid_q <= acc_bad | resp;
            err_q    <= acc_bad;
            rdata_q  <= resp & ~head.we ? ld : '0;
            if (acc_ok) begin
                req_q   <= 1'b1;
                we_q    <= lsu_we_i;
                addr_q  <= {lsu_addr_i[ADDR_W-1:OW], {OW{1'b0}}};
                be_q    <= BW'(size_mask(size)) << off;
                wdata_q <= lsu_wdata_i << {off, 3'b000};
            end else if (data_gnt_i) begin
                req_q <= 1'b0;
            end
        end
    end

    assert property (@(posedge clk) disable iff (rst) data_rvalid_i |-> !fifo_empty);

endmodule

// File: tb/tb_lsu_obi.sv
// tb_lsu_obi: directed and randomized checks of lsu_obi on 32- and 64-bit buses
module tb_lsu_obi;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid, we, sgn, gnt, rv;
    logic [1:0]  size;
    logic [31:0] addr, wdata, rd;
    logic        ready, rvo, err, busy, req, dwe;
    logic [31:0] rdo, daddr, dwd;
    logic [3:0]  be;

    logic        b_valid, b_we, b_sgn, b_gnt, b_rv;
    logic [1:0]  b_size;
    logic [31:0] b_addr;
    logic [63:0] b_wdata, b_rd;
    logic        b_ready, b_rvo, b_err, b_busy, b_req, b_dwe;
    logic [63:0] b_rdo, b_dwd;
    logic [31:0] b_daddr;
    logic [7:0]  b_be;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    lsu_obi #(.DATA_W(32), .ADDR_W(32), .MAX_OUTSTANDING(2)) dut (
        .clk(clk), .rst(rst),
        .lsu_valid_i(valid), .lsu_ready_o(ready), .lsu_we_i(we), .lsu_size_i(size),
        .lsu_signed_i(sgn), .lsu_addr_i(addr), .lsu_wdata_i(wdata),
        .lsu_rvalid_o(rvo), .lsu_rdata_o(rdo), .lsu_err_o(err), .busy_o(busy),
        .data_req_o(req), .data_gnt_i(gnt), .data_addr_o(daddr), .data_we_o(dwe),
        .data_be_o(be), .data_wdata_o(dwd), .data_rdata_i(rd), .data_rvalid_i(rv)
    );

    lsu_obi #(.DATA_W(64), .ADDR_W(32), .MAX_OUTSTANDING(2)) dut64 (
        .clk(clk), .rst(rst),
        .lsu_valid_i(b_valid), .lsu_ready_o(b_ready), .lsu_we_i(b_we), .lsu_size_i(b_size),
        .lsu_signed_i(b_sgn), .lsu_addr_i(b_addr), .lsu_wdata_i(b_wdata),
        .lsu_rvalid_o(b_rvo), .lsu_rdata_o(b_rdo), .lsu_err_o(b_err), .busy_o(b_busy),
        .data_req_o(b_req), .data_gnt_i(b_gnt), .data_addr_o(b_daddr), .data_we_o(b_dwe),
        .data_be_o(b_be), .data_wdata_o(b_dwd), .data_rdata_i(b_rd), .data_rvalid_i(b_rv)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic w, input logic [1:0] sz, input logic s,
                         input logic [31:0] a, input logic [31:0] wd);
        int n = 0;
        @(negedge clk);
        valid = 1'b1; we = w; size = sz; sgn = s; addr = a; wdata = wd;
        #1;
        while (!ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("accept_timeout", 64'(n < 50), 64'd1);
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic respond(input logic [31:0] d);
        rv = 1'b1;
        rd = d;
        @(negedge clk);
        rv = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        rwe, rs;
        logic [1:0]  rsz;
        logic [31:0] ra, rwd, rrd, exp_wd, exp_rd;
        logic [3:0]  exp_be;
        longint      m, v;
        int          nb, off;
        bit          legal;

        rst = 1'b1;
        {valid, we, sgn, gnt, rv, size, addr, wdata, rd} = '0;
        {b_valid, b_we, b_sgn, b_gnt, b_rv, b_size, b_addr, b_wdata, b_rd} = '0;
        repeat (2) @(negedge clk);
        chk("rst_ctl", {ready, rvo, err, busy, req, dwe}, 0);
        chk("rst_bus", {daddr, be}, 0);
        chk("rst_data", {rdo, dwd}, 0);
        chk("rst_ctl64", {b_ready, b_rvo, b_err, b_busy, b_req, b_dwe, b_be}, 0);
        rst = 1'b0;

        // signed byte load, granted immediately
        issue(1'b0, 2'd0, 1'b1, 32'h1003, 32'h0);
        gnt = 1'b1;
        chk("lb_req", req, 1);
        chk("lb_addr", daddr, 32'h1000);
        chk("lb_be", be, 4'h8);
        chk("lb_we", dwe, 0);
        @(negedge clk);
        gnt = 1'b0;
        chk("lb_req_drop", req, 0);
        respond(32'h80FF_FF12);
        chk("lb_rvalid", rvo, 1);
        chk("lb_rdata", rdo, 32'hFFFF_FF80);
        chk("lb_err", err, 0);
        @(negedge clk);
        chk("lb_idle", {rvo, busy}, 0);

        // halfword store with a three-cycle grant delay
        issue(1'b1, 2'd1, 1'b0, 32'h2002, 32'h0000_BEEF);
        for (int i = 0; i < 3; i++) begin
            chk("sh_wait_req", req, 1);
            chk("sh_wait_be", be, 4'hC);
            chk("sh_wait_addr", daddr, 32'h2000);
            chk("sh_wait_wdata", dwd, 32'hBEEF_0000);
            chk("sh_wait_ready", ready, 0);
            @(negedge clk);
        end
        gnt = 1'b1;
        chk("sh_we", dwe, 1);
        @(negedge clk);
        gnt = 1'b0;
        respond($urandom);
        chk("sh_resp", {rvo, err}, 2'b10);
        chk("sh_rdata", rdo, 0);

        // misaligned word load: immediate error response, no bus request
        issue(1'b0, 2'd2, 1'b0, 32'h3001, 32'h0);
        chk("misal_noreq", req, 0);
        chk("misal_resp", {rvo, err}, 2'b11);
        chk("misal_rdata", rdo, 0);
        @(negedge clk);
        chk("misal_pulse", rvo, 0);

        // misaligned access held off behind an outstanding load
        issue(1'b0, 2'd2, 1'b0, 32'h3000, 32'h0);
        gnt = 1'b1;
        @(negedge clk);
        gnt = 1'b0;
        valid = 1'b1; we = 1'b0; size = 2'd2; addr = 32'h3001;
        #1;
        chk("err_block0", ready, 0);
        @(negedge clk);
        #1;
        chk("err_block1", ready, 0);
        chk("err_block_noresp", rvo, 0);
        rv = 1'b1;
        rd = 32'hCAFE_F00D;
        #1;
        chk("err_block2", ready, 0);
        @(negedge clk);
        rv = 1'b0;
        #1;
        chk("ld_before_err", {rvo, err}, 2'b10);
        chk("ld_before_err_rdata", rdo, 32'hCAFE_F00D);
        chk("err_unblock", ready, 1);
        @(negedge clk);
        valid = 1'b0;
        chk("err_after_ld", {rvo, err}, 2'b11);
        chk("err_after_ld_rdata", rdo, 0);

        // three back-to-back word loads against two outstanding slots
        @(negedge clk);
        valid = 1'b1; we = 1'b0; size = 2'd2; sgn = 1'b0; addr = 32'h5000; gnt = 1'b1;
        #1;
        chk("b2b_r1", ready, 1);
        @(negedge clk);
        addr = 32'h5004;
        #1;
        chk("b2b_req1", req, 1);
        chk("b2b_addr1", daddr, 32'h5000);
        chk("b2b_r2", ready, 1);
        @(negedge clk);
        addr = 32'h5008;
        #1;
        chk("b2b_req2", req, 1);
        chk("b2b_addr2", daddr, 32'h5004);
        chk("b2b_r3_stall", ready, 0);
        @(negedge clk);
        gnt = 1'b0;
        #1;
        chk("b2b_req_drop", req, 0);
        chk("b2b_stall", ready, 0);
        repeat (2) begin
            @(negedge clk);
            #1;
            chk("b2b_stall_hold", ready, 0);
            chk("b2b_busy", busy, 1);
        end
        rv = 1'b1;
        rd = 32'h1111_1111;
        #1;
        chk("b2b_stall_rv", ready, 0);
        @(negedge clk);
        rd = 32'h2222_2222;
        #1;
        chk("b2b_resp1_v", rvo, 1);
        chk("b2b_resp1", rdo, 32'h1111_1111);
        chk("b2b_r3_accept", ready, 1);
        @(negedge clk);
        valid = 1'b0; rv = 1'b0; gnt = 1'b1;
        #1;
        chk("b2b_resp2_v", rvo, 1);
        chk("b2b_resp2", rdo, 32'h2222_2222);
        chk("b2b_req3", req, 1);
        chk("b2b_addr3", daddr, 32'h5008);
        @(negedge clk);
        gnt = 1'b0;
        respond(32'h3333_3333);
        chk("b2b_resp3", rdo, 32'h3333_3333);
        @(negedge clk);
        chk("b2b_idle", busy, 0);

        // doubleword on a 32-bit bus is illegal
        issue(1'b0, 2'd3, 1'b0, 32'h6000, 32'h0);
        chk("ld32_noreq", req, 0);
        chk("ld32_err", {rvo, err}, 2'b11);

        // 64-bit bus: unsigned halfword in the top lane, signed word in the upper half
        @(negedge clk);
        b_valid = 1'b1; b_we = 1'b0; b_size = 2'd1; b_sgn = 1'b0; b_addr = 32'h4006;
        #1;
        chk("w64_ready", b_ready, 1);
        @(negedge clk);
        b_valid = 1'b0; b_gnt = 1'b1;
        chk("w64_req", b_req, 1);
        chk("w64_be", b_be, 8'hC0);
        chk("w64_addr", b_daddr, 32'h4000);
        @(negedge clk);
        b_gnt = 1'b0; b_rv = 1'b1; b_rd = 64'hABCD_0000_0000_0000;
        @(negedge clk);
        b_rv = 1'b0;
        chk("w64_lhu", {b_rvo, b_err}, 2'b10);
        chk("w64_lhu_data", b_rdo, 64'h0000_0000_0000_ABCD);
        b_valid = 1'b1; b_size = 2'd2; b_sgn = 1'b1; b_addr = 32'h4004;
        @(negedge clk);
        b_valid = 1'b0; b_gnt = 1'b1;
        chk("w64_lw_be", b_be, 8'hF0);
        @(negedge clk);
        b_gnt = 1'b0; b_rv = 1'b1; b_rd = 64'h8765_4321_0000_0000;
        @(negedge clk);
        b_rv = 1'b0;
        chk("w64_lw_data", b_rdo, 64'hFFFF_FFFF_8765_4321);

        // reset with two loads in flight, then a stray response
        issue(1'b0, 2'd2, 1'b0, 32'h7000, 32'h0);
        gnt = 1'b1;
        @(negedge clk);
        gnt = 1'b0;
        issue(1'b0, 2'd0, 1'b0, 32'h7001, 32'h0);
        chk("pre_rst", {busy, req}, 2'b11);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_ctl", {ready, rvo, err, busy, req, dwe}, 0);
        chk("mid_rst_bus", {daddr, be}, 0);
        chk("mid_rst_data", {rdo, dwd}, 0);
        rv = 1'b1;
        rd = 32'hDEAD_BEEF;
        @(negedge clk);
        rv = 1'b0;
        chk("stray_norv", rvo, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", ready, 1);
        chk("post_rst_busy", busy, 0);
        @(negedge clk);
        chk("post_rst_stray", {rvo, busy}, 0);
        issue(1'b0, 2'd0, 1'b0, 32'h7001, 32'h0);
        gnt = 1'b1;
        @(negedge clk);
        gnt = 1'b0;
        respond(32'h0000_AB00);
        chk("post_rst_flush", rdo, 32'h0000_00AB);

        // randomized single accesses against an arithmetic reference
        for (int t = 0; t < 60; t++) begin
            rwe = 1'($urandom); rsz = 2'($urandom); rs = 1'($urandom);
            ra = $urandom; rwd = $urandom; rrd = $urandom;
            nb = 1 << rsz;
            if ($urandom_range(0, 3) != 0) ra = ra - ra % nb;
            off = ra % 4;
            legal = rsz != 2'd3 && off % nb == 0;
            issue(rwe, rsz, rs, ra, rwd);
            if (!legal) begin
                chk("rnd_err", {req, rvo, err}, 3'b011);
                chk("rnd_err_data", rdo, 0);
            end else begin
                exp_be = 4'(((1 << nb) - 1) << off);
                exp_wd = 32'(64'(rwd) << (8 * off));
                repeat ($urandom_range(0, 2)) begin
                    chk("rnd_wait", {req, ready}, 2'b10);
                    chk("rnd_wait_be", be, exp_be);
                    @(negedge clk);
                end
                gnt = 1'b1;
                chk("rnd_req", req, 1);
                chk("rnd_addr", daddr, ra - off);
                chk("rnd_be", be, exp_be);
                chk("rnd_we", dwe, rwe);
                if (rwe) chk("rnd_wdata", dwd, exp_wd);
                @(negedge clk);
                gnt = 1'b0;
                repeat ($urandom_range(0, 2)) @(negedge clk);
                respond(rrd);
                m = (64'd1 << (8 * nb)) - 1;
                v = (64'(rrd) >> (8 * off)) & m;
                if (rs && v[8 * nb - 1]) v = v | ~m;
                exp_rd = rwe ? 32'h0 : 32'(v);
                chk("rnd_resp", {rvo, err}, 2'b10);
                chk("rnd_rdata", rdo, exp_rd);
            end
        end

        @(negedge clk);
        chk("final_idle", busy, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
